wb_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arb_rr_picker.sv | 33 +++
 rtl/wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// State encodings, the default forced-termination read data and the watchdog width.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int          WDOG_CNT_W           = 16;
    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin picker: first set bit of req scanning from last+1 modulo N.
// Kept generic so the interrupt-priority block can reuse it.
module wb_arb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             valid
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one interconnect port between N_MASTERS masters.
// Define WB_ARBITER_TIMEOUT_EN to build the stalled-strobe watchdog (ABORT state, timeout_o).
//
// state    | meaning
// ST_IDLE  | no grant, bus outputs parked at 0
// ST_GRANT | master 'last' owns the bus until its cyc drops
// ST_ABORT | one-cycle forced termination of a stalled transfer
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int          N_MASTERS      = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_MASTERS-1:0]    wbs_cyc_i,
    input  logic [N_MASTERS-1:0]    wbs_stb_i,
    input  logic [N_MASTERS-1:0]    wbs_we_i,
    input  logic [N_MASTERS*32-1:0] wbs_addr_i,
    input  logic [N_MASTERS*32-1:0] wbs_data_i,
    input  logic [N_MASTERS*4-1:0]  wbs_sel_i,
    output logic [N_MASTERS-1:0]    wbs_ack_o,
    output logic [31:0]             wbs_data_o,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [31:0]             wbm_addr_o,
    output logic [31:0]             wbm_data_o,
    output logic [3:0]              wbm_sel_o,
    input  logic                    wbm_ack_i,
    input  logic [31:0]             wbm_data_i,
    output logic [N_MASTERS-1:0]    grant_o,
    output logic                    timeout_o
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    arb_state_t           state;
    logic [IDX_W-1:0]     last;
    logic [N_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 own_cyc;
    logic                 wd_hit;

    wb_arb_rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (wbs_cyc_i),
        .last    (last),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

    // 'last' doubles as the owner index while a grant is held
    assign own_cyc = wbs_cyc_i[last];

    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_addr_o = '0;
        wbm_data_o = '0;
        wbm_sel_o  = '0;
        wbs_ack_o  = '0;
        wbs_data_o = wbm_data_i;
        if (state == ST_GRANT) begin
            wbm_cyc_o       = own_cyc;
            wbm_stb_o       = own_cyc & wbs_stb_i[last];
            wbm_we_o        = wbs_we_i[last];
            wbm_addr_o      = wbs_addr_i[32*last +: 32];
            wbm_data_o      = wbs_data_i[32*last +: 32];
            wbm_sel_o       = wbs_sel_i[4*last +: 4];
            wbs_ack_o[last] = wbm_ack_i;
        end else if (state == ST_ABORT) begin
            wbs_ack_o[last] = 1'b1;
            wbs_data_o      = TIMEOUT_DATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            last    <= IDX_W'(N_MASTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state   <= ST_GRANT;
                        grant_o <= pick_gnt;
                        last    <= pick_idx;
                    end
                end
                ST_GRANT, ST_ABORT: begin
                    // owner's cyc low: hand over on this same edge, the picker already skips the owner
                    if (!own_cyc) begin
                        if (pick_valid) begin
                            state   <= ST_GRANT;
                            grant_o <= pick_gnt;
                            last    <= pick_idx;
                        end else begin
                            state   <= ST_IDLE;
                            grant_o <= '0;
                        end
                    end else if (state == ST_ABORT) begin
                        state <= ST_GRANT;
                    end else if (wd_hit) begin
                        state <= ST_ABORT;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam logic [WDOG_CNT_W-1:0] WDOG_LIMIT = WDOG_CNT_W'(TIMEOUT_CYCLES);

    logic [WDOG_CNT_W-1:0] wdog_cnt;
    logic                  timeout_q;

    // compared before incrementing, so the abort lands TIMEOUT_CYCLES+1 cycles after strobe start
    assign wd_hit = (state == ST_GRANT) && wbm_stb_o && !wbm_ack_i && (wdog_cnt == WDOG_LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_hit;
            if (state != ST_GRANT || !own_cyc || wbm_ack_i || wd_hit) begin
                wdog_cnt <= '0;
            end else if (wbm_stb_o) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level ownership model.
module tb_wb_arbiter;

    localparam int          N       = 2;
    localparam int          T       = 4;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
`ifdef WB_ARBITER_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic            clk;
    logic            resetn;
    logic [N-1:0]    cyc, stb, we;
    logic [N*32-1:0] addr, wdat;
    logic [N*4-1:0]  sel;
    logic [N-1:0]    wbs_ack_o;
    logic [31:0]     wbs_data_o;
    logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0]     wbm_addr_o, wbm_data_o;
    logic [3:0]      wbm_sel_o;
    logic            ack_i;
    logic [31:0]     rdat;
    logic [N-1:0]    grant_o;
    logic            timeout_o;

    int n_chk;
    int n_fail;

    wb_arbiter #(
        .N_MASTERS      (N),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_DATA   (TO_DATA)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_addr_i (addr),
        .wbs_data_i (wdat),
        .wbs_sel_i  (sel),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_data_o (wbs_data_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_addr_o (wbm_addr_o),
        .wbm_data_o (wbm_data_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_ack_i  (ack_i),
        .wbm_data_i (rdat),
        .grant_o    (grant_o),
        .timeout_o  (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0; addr = '0; wdat = '0; sel = '0;
        ack_i = 1'b0; rdat = '0;
    endtask

    task automatic randomize_inputs();
        cyc   = N'($urandom);
        stb   = N'($urandom);
        we    = N'($urandom);
        addr  = {$urandom, $urandom};
        wdat  = {$urandom, $urandom};
        sel   = (N*4)'($urandom);
        ack_i = 1'($urandom);
        rdat  = $urandom;
    endtask

    // masters hold cyc for a while; slave acks about a third of the time
    task automatic traffic_inputs();
        for (int k = 0; k < N; k++) begin
            if (cyc[k]) begin
                if ($urandom_range(0, 7) == 0) cyc[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                cyc[k] = 1'b1;
            end
            stb[k]         = cyc[k] && ($urandom_range(0, 3) != 0);
            we[k]          = 1'($urandom);
            addr[k*32 +: 32] = $urandom;
            wdat[k*32 +: 32] = $urandom;
            sel[k*4 +: 4]  = 4'($urandom);
        end
        ack_i = ($urandom_range(0, 2) == 0);
        rdat  = $urandom;
    endtask

    // ---------------- reference model: who owns the bus, and is it being aborted ----------------
    int m_owner;
    int m_last;
    bit m_abort;
    int m_stall;

    function automatic int rr_pick(input int from);
        for (int k = 1; k <= N; k++) begin
            if (cyc[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_owner = -1;
            m_last  = N - 1;
            m_abort = 1'b0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            m_owner = rr_pick(m_last);
            if (m_owner >= 0) m_last = m_owner;
            m_stall = 0;
        end else if (!cyc[m_owner]) begin
            m_owner = rr_pick(m_owner);
            if (m_owner >= 0) m_last = m_owner;
            m_abort = 1'b0;
            m_stall = 0;
        end else if (m_abort) begin
            m_abort = 1'b0;
            m_stall = 0;
        end else if (WD && stb[m_owner] && !ack_i && m_stall == T) begin
            m_abort = 1'b1;
            m_stall = 0;
        end else if (ack_i) begin
            m_stall = 0;
        end else if (stb[m_owner]) begin
            m_stall = m_stall + 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] e_grant, e_ack;
        logic         e_cyc, e_stb, e_we, e_to;
        logic [31:0]  e_addr, e_wdat, e_rdat;
        logic [3:0]   e_sel;
        e_grant = '0; e_ack = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_to = 1'b0;
        e_addr = '0; e_wdat = '0; e_sel = '0; e_rdat = rdat;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            if (m_abort) begin
                e_ack[m_owner] = 1'b1;
                e_rdat         = TO_DATA;
                e_to           = 1'b1;
            end else begin
                e_cyc          = cyc[m_owner];
                e_stb          = cyc[m_owner] & stb[m_owner];
                e_we           = we[m_owner];
                e_addr         = addr[m_owner*32 +: 32];
                e_wdat         = wdat[m_owner*32 +: 32];
                e_sel          = sel[m_owner*4 +: 4];
                e_ack[m_owner] = ack_i;
            end
        end
        chk("grant_o", 64'(grant_o), 64'(e_grant));
        chk("wbs_ack_o", 64'(wbs_ack_o), 64'(e_ack));
        chk("wbs_data_o", 64'(wbs_data_o), 64'(e_rdat));
        chk("timeout_o", 64'(timeout_o), 64'(e_to));
        chk("wbm_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}),
            64'({e_cyc, e_stb, e_we, e_sel}));
        chk("wbm_addr_data", {wbm_addr_o, wbm_data_o}, {e_addr, e_wdat});
    end

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        int start_i;
        int hit_i;
        int n_wr;
        n_chk  = 0;
        n_fail = 0;
        clear_inputs();
        resetn = 1'b0;

        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            mid();
            chk("rst_grant", 64'(grant_o), 64'd0);
            chk("rst_wbm_cyc", 64'(wbm_cyc_o), 64'd0);
            chk("rst_ack", 64'(wbs_ack_o), 64'd0);
            chk("rst_timeout", 64'(timeout_o), 64'd0);
            step();
        end
        clear_inputs();
        resetn = 1'b1;

        // single master read
        step();
        cyc[1] = 1'b1; stb[1] = 1'b1; addr[63:32] = 32'h0000_9008; sel[7:4] = 4'hF;
        mid();
        chk("sm_pre_grant", 64'(grant_o), 64'd0);
        step();
        mid();
        chk("sm_grant", 64'(grant_o), 64'b10);
        chk("sm_cyc", 64'(wbm_cyc_o), 64'd1);
        chk("sm_addr", 64'(wbm_addr_o), 64'h9008);
        step();
        mid();
        chk("sm_stall_ack", 64'(wbs_ack_o), 64'd0);
        step();
        ack_i = 1'b1; rdat = 32'h1;
        mid();
        chk("sm_ack", 64'(wbs_ack_o), 64'b10);
        chk("sm_data", 64'(wbs_data_o), 64'h1);
        step();
        clear_inputs();
        step();
        mid();
        chk("sm_idle", 64'(grant_o), 64'd0);

        // contention from reset, handover, then repeat pairs
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        cyc = 2'b11; stb = 2'b11;
        step();
        mid();
        chk("ct_first", 64'(grant_o), 64'b01);
        step();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        mid();
        chk("ct_drop_cyc", 64'(wbm_cyc_o), 64'd0);
        step();
        mid();
        chk("ct_handover", 64'(grant_o), 64'b10);
        chk("ct_handover_cyc", 64'(wbm_cyc_o), 64'd1);
        step();
        cyc = 2'b00; stb = 2'b00;
        step();
        cyc = 2'b11; stb = 2'b11;
        step();
        mid();
        chk("ct_pair_after_m1", 64'(grant_o), 64'b01);
        step();
        cyc = 2'b00; stb = 2'b00;
        step();
        cyc = 2'b11; stb = 2'b11;
        step();
        mid();
        chk("ct_repeat_pair", 64'(grant_o), 64'b10);
        step();
        clear_inputs();
        step();

        // hold: master 0 does three writes while master 1 waits
        cyc = 2'b11; stb = 2'b11; we = 2'b01; ack_i = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            addr[31:0] = 32'(4 * i);
            mid();
            chk("hold_grant", 64'(grant_o), 64'b01);
            chk("hold_addr", 64'(wbm_addr_o), 64'(4 * i));
            if (wbm_cyc_o && wbm_stb_o && wbm_we_o && ack_i) n_wr++;
        end
        step();
        cyc[0] = 1'b0; stb[0] = 1'b0; ack_i = 1'b0;
        mid();
        chk("hold_still_m0", 64'(grant_o), 64'b01);
        step();
        mid();
        chk("hold_m1_after", 64'(grant_o), 64'b10);
        chk("hold_writes", 64'(n_wr), 64'd3);
        step();
        clear_inputs();
        step();

        // stalled slave: watchdog abort, or indefinite stall without it
        cyc[1] = 1'b1; stb[1] = 1'b1; addr[63:32] = 32'h0000_9008;
        step();
        start_i = -1;
        hit_i   = -1;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (wbm_stb_o && start_i < 0) start_i = i;
            if (timeout_o) begin
                hit_i = i;
                break;
            end
            step();
        end
        if (WD) begin
            chk("wd_latency", 64'(hit_i - start_i), 64'd5);
            chk("wd_ack", 64'(wbs_ack_o), 64'b10);
            chk("wd_data", 64'(wbs_data_o), 64'hDEAD_BEEF);
            chk("wd_cyc_low", 64'(wbm_cyc_o), 64'd0);
        end else begin
            mid();
            chk("nowd_no_timeout", 64'(hit_i), 64'hFFFF_FFFF_FFFF_FFFF);
            chk("nowd_still_stalled", 64'({wbm_cyc_o, wbs_ack_o}), 64'b100);
        end
        step();
        clear_inputs();
        step();
        step();

        // reset during a granted stall
        cyc[1] = 1'b1; stb[1] = 1'b1;
        step();
        mid();
        chk("rm_grant", 64'(grant_o), 64'b10);
        step();
        resetn = 1'b0;
        cyc = 2'b11; stb = 2'b11;
        #1;
        chk("rm_grant_cleared", 64'(grant_o), 64'd0);
        chk("rm_cyc_cleared", 64'(wbm_cyc_o), 64'd0);
        step();
        resetn = 1'b1;
        step();
        mid();
        chk("rm_m0_first", 64'(grant_o), 64'b01);
        step();
        clear_inputs();
        step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 499) == 0) begin
                resetn = 1'b0;
                randomize_inputs();
                step();
                resetn = 1'b1;
            end
            traffic_inputs();
        end

        step();
        clear_inputs();
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit reached");
    end

endmodule
